// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select codes, default datapath width
// and the EX/MEM control bundle.
package pipe_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  localparam logic [1:0] FWD_IN  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       sw1;
    logic       sm2;
    logic       sw2;
    logic       mw;
    logic [2:0] ra;
    logic [2:0] rb;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/fwd_mux4.sv
// 4:1 operand bypass mux, selected by a forward code from the hazard unit.
module fwd_mux4
  import pipe_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [1:0]   sel_i,
  input  logic [W-1:0] rf_i,
  input  logic [W-1:0] mem_i,
  input  logic [W-1:0] wb_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] op_o
);

  always_comb begin
    op_o = rf_i;
    case (sel_i)
      FWD_RF:  op_o = rf_i;
      FWD_MEM: op_o = mem_i;
      FWD_WB:  op_o = wb_i;
      FWD_IN:  op_o = in_i;
      default: op_o = rf_i;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-stage operand bypass plus EX/MEM pipeline register with bubble
// insertion, saturating bubble counter and sticky stall watchdog.
module ex_mem_stage #(
  parameter int DATA_W    = 8,
  parameter int STALL_MAX = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] rf_a_ex,
  input  logic [DATA_W-1:0] rf_b_ex,
  input  logic [DATA_W-1:0] wb_data_wb,
  input  logic [DATA_W-1:0] in_port_wb,
  input  logic [DATA_W-1:0] alu_res_ex,
  input  logic              we_ex,
  input  logic              sw1_ex,
  input  logic              sm2_ex,
  input  logic              sw2_ex,
  input  logic              mw_ex,
  input  logic [2:0]        ra_ex,
  input  logic [2:0]        rb_ex,
  output logic [DATA_W-1:0] op_a_ex,
  output logic [DATA_W-1:0] op_b_ex,
  output logic              valid_mem,
  output logic              we_mem,
  output logic              sw1_mem,
  output logic              sm2_mem,
  output logic              sw2_mem,
  output logic              mw_mem,
  output logic [2:0]        ra_mem,
  output logic [2:0]        rb_mem,
  output logic [DATA_W-1:0] alu_res_mem,
  output logic [DATA_W-1:0] store_data_mem,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_err
);
  import pipe_pkg::*;

  localparam int RUN_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

  ex_mem_ctrl_t      ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              err_q, err_d;
  logic              bubble;

  fwd_mux4 #(.W(DATA_W)) u_mux_a (
    .sel_i(forward_a), .rf_i(rf_a_ex), .mem_i(alu_q),
    .wb_i(wb_data_wb), .in_i(in_port_wb), .op_o(op_a_ex)
  );

  fwd_mux4 #(.W(DATA_W)) u_mux_b (
    .sel_i(forward_b), .rf_i(rf_b_ex), .mem_i(alu_q),
    .wb_i(wb_data_wb), .in_i(in_port_wb), .op_o(op_b_ex)
  );

  assign bubble = stall | flush;

  always_comb begin
    ctrl_d = '0;
    alu_d  = '0;
    sd_d   = '0;
    cnt_d  = cnt_q;
    if (bubble) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ctrl_d = '{valid: 1'b1, we: we_ex, sw1: sw1_ex, sm2: sm2_ex,
                 sw2: sw2_ex, mw: mw_ex, ra: ra_ex, rb: rb_ex};
      alu_d  = alu_res_ex;
      sd_d   = op_b_ex;
    end
  end

  // A flush during a stall is a branch kill, not a hazard stall, so it breaks the run.
  always_comb begin
    run_d = '0;
    if (stall && !flush)
      run_d = (run_q == RUN_W'(STALL_MAX)) ? run_q : run_q + RUN_W'(1);
    err_d = err_q | (run_d == RUN_W'(STALL_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      sd_q   <= '0;
      cnt_q  <= '0;
      run_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      sd_q   <= sd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      err_q  <= err_d;
    end
  end

  assign valid_mem      = ctrl_q.valid;
  assign we_mem         = ctrl_q.we;
  assign sw1_mem        = ctrl_q.sw1;
  assign sm2_mem        = ctrl_q.sm2;
  assign sw2_mem        = ctrl_q.sw2;
  assign mw_mem         = ctrl_q.mw;
  assign ra_mem         = ctrl_q.ra;
  assign rb_mem         = ctrl_q.rb;
  assign alu_res_mem    = alu_q;
  assign store_data_mem = sd_q;
  assign bubble_cnt     = cnt_q;
  assign stall_err      = err_q;

endmodule
